// File: rtl/tl_traffic_queue.sv
// tl_traffic_queue: intersection queue model feeding sensors to the left-turn traffic light controller (optional TL_SAFETY_CHK_EN adds conflict)
module tl_traffic_queue #(
    parameter int CNT_W   = 4,
    parameter int DEP_CYC = 4,
    parameter int SRV_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             arr_a,
    input  logic             arr_al,
    input  logic             arr_b,
    input  logic             arr_bl,
    output logic             Ta,
    output logic             Tal,
    output logic             Tb,
    output logic             Tbl,
    output logic [CNT_W-1:0] q_a,
    output logic [CNT_W-1:0] q_al,
    output logic [CNT_W-1:0] q_b,
    output logic [CNT_W-1:0] q_bl,
    output logic             drop,
    output logic [SRV_W-1:0] served
`ifdef TL_SAFETY_CHK_EN
    ,
    output logic             conflict
`endif
);
    localparam int PC_W = $clog2(DEP_CYC);
    localparam logic [1:0] GREEN = 2'b00;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RED   = 2'b11;
    localparam logic [CNT_W-1:0] QMAX = '1;

    logic [CNT_W-1:0] q     [4];
    logic [CNT_W-1:0] q_nxt [4];
    logic [3:0]       arr, dep, lost;
    logic [PC_W-1:0]  pc_a, pc_b;
    logic [1:0]       prev_la, prev_lb;
    logic             hold_a, hold_b, tick_a, tick_b;

    assign arr  = {arr_bl, arr_b, arr_al, arr_a};
    assign q_a  = q[0];
    assign q_al = q[1];
    assign q_b  = q[2];
    assign q_bl = q[3];
    assign Ta   = q[0] != '0;
    assign Tal  = q[1] != '0;
    assign Tb   = q[2] != '0;
    assign Tbl  = q[3] != '0;

    // departure pacing and per-queue next counts; a simultaneous arrival and departure cancel
    always_comb begin
        hold_a = La == prev_la && (La == GREEN || La == LEFT);
        hold_b = Lb == prev_lb && (Lb == GREEN || Lb == LEFT);
        tick_a = hold_a && pc_a == PC_W'(DEP_CYC - 1);
        tick_b = hold_b && pc_b == PC_W'(DEP_CYC - 1);
        dep = {tick_b && Lb == LEFT  && q[3] != '0,
               tick_b && Lb == GREEN && q[2] != '0,
               tick_a && La == LEFT  && q[1] != '0,
               tick_a && La == GREEN && q[0] != '0};
        for (int i = 0; i < 4; i++) begin
            q_nxt[i] = (arr[i] && !dep[i] && q[i] != QMAX) ? q[i] + CNT_W'(1) :
                       (!arr[i] && dep[i]) ? q[i] - CNT_W'(1) : q[i];
            lost[i]  = arr[i] && !dep[i] && q[i] == QMAX;
        end
    end

    // queue, pacing and statistics state
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 4; i++) q[i] <= '0;
            pc_a    <= '0;
            pc_b    <= '0;
            prev_la <= RED;
            prev_lb <= RED;
            drop    <= 1'b0;
            served  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) q[i] <= q_nxt[i];
            pc_a    <= (!hold_a || tick_a) ? '0 : pc_a + PC_W'(1);
            pc_b    <= (!hold_b || tick_b) ? '0 : pc_b + PC_W'(1);
            prev_la <= La;
            prev_lb <= Lb;
            drop    <= drop | (|lost);
            served  <= served + SRV_W'($countones(dep));
        end
    end

`ifdef TL_SAFETY_CHK_EN
    // sticky flag for both streets showing a non-red code at once
    always_ff @(posedge clk) begin
        if (reset_n) conflict <= 1'b0;
        else if (La != RED && Lb != RED) conflict <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_tl_traffic_queue.sv
// tb_tl_traffic_queue: directed and randomized checks of tl_traffic_queue against a queue-level reference model
module tb_tl_traffic_queue;
    localparam int CNT_W = 4;
    localparam int DEP   = 4;
    localparam int SRV_W = 8;
    localparam int QMAX  = 15;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [1:0]       la = 2'b11, lb = 2'b11;
    logic             arr_a = 1'b0, arr_al = 1'b0, arr_b = 1'b0, arr_bl = 1'b0;
    logic             ta, tal, tb, tbl, drop;
    logic [CNT_W-1:0] q_a, q_al, q_b, q_bl;
    logic [SRV_W-1:0] served;
    logic             conflict;

    int checks = 0;
    int failures = 0;

    int mq [4];
    int mdrop, mserved, mconf, pla, plb, run_a, run_b;

    always #5 clk = ~clk;

    tl_traffic_queue #(.CNT_W(CNT_W), .DEP_CYC(DEP), .SRV_W(SRV_W)) dut (
        .clk(clk), .reset_n(reset_n), .La(la), .Lb(lb),
        .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
        .Ta(ta), .Tal(tal), .Tb(tb), .Tbl(tbl),
        .q_a(q_a), .q_al(q_al), .q_b(q_b), .q_bl(q_bl),
        .drop(drop), .served(served)
`ifdef TL_SAFETY_CHK_EN
        , .conflict(conflict)
`endif
    );

`ifndef TL_SAFETY_CHK_EN
    assign conflict = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // reference: counts of cycles since each light last changed; a permitting light
    // releases one vehicle every DEP cycles of holding
    task automatic model_step(input int l_a, input int l_b, input logic [3:0] arr, input logic rst);
        logic [3:0] dep;
        bit tk_a, tk_b;
        if (rst) begin
            mq = '{0, 0, 0, 0};
            mdrop = 0; mserved = 0; mconf = 0;
            pla = 3; plb = 3; run_a = 0; run_b = 0;
            return;
        end
        if (l_a != 3 && l_b != 3) mconf = 1;
        run_a = (l_a != pla) ? 0 : run_a + 1;
        run_b = (l_b != plb) ? 0 : run_b + 1;
        tk_a = (l_a == 0 || l_a == 2) && run_a > 0 && run_a % DEP == 0;
        tk_b = (l_b == 0 || l_b == 2) && run_b > 0 && run_b % DEP == 0;
        dep[0] = tk_a && l_a == 0 && mq[0] > 0;
        dep[1] = tk_a && l_a == 2 && mq[1] > 0;
        dep[2] = tk_b && l_b == 0 && mq[2] > 0;
        dep[3] = tk_b && l_b == 2 && mq[3] > 0;
        for (int i = 0; i < 4; i++) begin
            if (dep[i]) begin
                mserved++;
                if (!arr[i]) mq[i]--;
            end else if (arr[i]) begin
                if (mq[i] == QMAX) mdrop = 1;
                else mq[i]++;
            end
        end
        mserved = mserved % (1 << SRV_W);
        pla = l_a;
        plb = l_b;
    endtask

    task automatic check_all();
        chk("q_a", q_a, mq[0]);
        chk("q_al", q_al, mq[1]);
        chk("q_b", q_b, mq[2]);
        chk("q_bl", q_bl, mq[3]);
        chk("Ta", ta, mq[0] != 0);
        chk("Tal", tal, mq[1] != 0);
        chk("Tb", tb, mq[2] != 0);
        chk("Tbl", tbl, mq[3] != 0);
        chk("drop", drop, mdrop);
        chk("served", served, mserved);
`ifdef TL_SAFETY_CHK_EN
        chk("conflict", conflict, mconf);
`endif
    endtask

    task automatic step(input logic [1:0] l_a, input logic [1:0] l_b, input logic [3:0] arr, input logic rst);
        la = l_a; lb = l_b;
        {arr_bl, arr_b, arr_al, arr_a} = arr;
        reset_n = rst;
        @(posedge clk);
        model_step(int'(l_a), int'(l_b), arr, rst);
        #1;
        check_all();
    endtask

    initial begin
        int s0;
        logic [1:0] rla, rlb;
        // reset while arrivals pulse: reset wins
        step(2'b11, 2'b11, 4'b1111, 1'b1);
        step(2'b11, 2'b11, 4'b0000, 1'b1);
        chk("rst_q_a", q_a, 0);
        chk("rst_served", served, 0);
        chk("rst_drop", drop, 0);
        // three arrivals on A straight under red
        step(2'b11, 2'b11, 4'b0001, 1'b0);
        chk("ta_after_first", ta, 1);
        step(2'b11, 2'b11, 4'b0000, 1'b0);
        step(2'b11, 2'b11, 4'b0001, 1'b0);
        step(2'b11, 2'b11, 4'b0001, 1'b0);
        chk("q_a_three", q_a, 3);
        chk("served_zero", served, 0);
        // green on A drains one vehicle every DEP cycles
        for (int k = 0; k <= 12; k++) begin
            step(2'b00, 2'b11, 4'b0000, 1'b0);
            if (k % DEP == 0) chk("drain_q_a", q_a, 3 - k / DEP);
        end
        chk("drain_ta", ta, 0);
        chk("drain_served", served, 3);
        // left queue under red, brief green, then LEFT restarts pacing
        step(2'b11, 2'b11, 4'b0011, 1'b0);
        step(2'b11, 2'b11, 4'b0010, 1'b0);
        for (int k = 0; k < 3; k++) step(2'b00, 2'b11, 4'b0000, 1'b0);
        chk("q_a_pre_left", q_a, 1);
        for (int k = 0; k <= 8; k++) begin
            step(2'b10, 2'b11, 4'b0000, 1'b0);
            if (k % DEP == 0) chk("left_q_al", q_al, 2 - k / DEP);
            chk("left_q_a_held", q_a, 1);
        end
        // fill B straight to capacity, then overflow
        for (int k = 0; k < QMAX; k++) step(2'b11, 2'b11, 4'b0100, 1'b0);
        chk("full_q_b", q_b, QMAX);
        chk("full_no_drop", drop, 0);
        step(2'b11, 2'b11, 4'b0100, 1'b0);
        chk("ovf_q_b", q_b, QMAX);
        chk("ovf_drop", drop, 1);
        for (int k = 0; k < 3; k++) step(2'b11, 2'b11, 4'b0000, 1'b0);
        chk("drop_sticky", drop, 1);
        // B left: arrival coinciding with a departure tick
        for (int k = 0; k < 5; k++) step(2'b11, 2'b11, 4'b1000, 1'b0);
        s0 = mserved;
        for (int k = 0; k < DEP; k++) step(2'b11, 2'b10, 4'b0000, 1'b0);
        step(2'b11, 2'b10, 4'b1000, 1'b0);
        chk("coincide_q_bl", q_bl, 5);
        chk("coincide_served", served, s0 + 1);
        step(2'b11, 2'b10, 4'b1111, 1'b1);
        chk("mid_rst_q_bl", q_bl, 0);
        chk("mid_rst_q_b", q_b, 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_served", served, 0);
        chk("mid_rst_tbl", tbl, 0);
`ifdef TL_SAFETY_CHK_EN
        step(2'b11, 2'b11, 4'b0000, 1'b0);
        chk("conflict_clear", conflict, 0);
        step(2'b00, 2'b01, 4'b0000, 1'b0);
        chk("conflict_set", conflict, 1);
        step(2'b11, 2'b11, 4'b0000, 1'b0);
        step(2'b11, 2'b11, 4'b0000, 1'b0);
        chk("conflict_sticky", conflict, 1);
        step(2'b11, 2'b11, 4'b0000, 1'b1);
        chk("conflict_rst", conflict, 0);
`endif
        // randomized traffic with held lights and occasional resets
        rla = 2'b11; rlb = 2'b11;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(11) == 0) rla = 2'($urandom_range(3));
            if ($urandom_range(11) == 0) rlb = 2'($urandom_range(3));
            step(rla, rlb,
                 {$urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0},
                 $urandom_range(299) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tl_traffic_queue.md
Name: tl_traffic_queue

Overview:
- Intersection model that drives the sensor side of the left-turn traffic light controller.
- It consumes the controller's light codes La/Lb and produces the sensor inputs Ta/Tal/Tb/Tbl from four vehicle-queue counters: A straight, A left, B straight and B left.
- Vehicles arrive on pulse inputs and depart at a paced rate while their light permits.
- It closes the loop with the controller in system-level simulation and on the FPGA board.

Parameters:
- CNT_W, 4: width of each queue counter; capacity is 2^CNT_W-1 (15).
- DEP_CYC, 4: cycles between successive departures from a permitted queue; legal range 2..16.
- SRV_W, 8: width of the wrapping served-vehicle counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-high reset; sampled on the rising edge of clk, and a 1 resets all state.
- La  input  2  street A light code: 00 GREEN, 01 YELLOW, 10 LEFT, 11 RED.
- Lb  input  2  street B light code, same encoding as La.
- arr_a, arr_al, arr_b, arr_bl  input  1 each  one-cycle arrival pulses for A straight, A left, B straight and B left.
- Ta, Tal, Tb, Tbl  output  1 each  sensors; high while the matching queue is nonzero.
- q_a, q_al, q_b, q_bl  output  CNT_W each  current queue counts.
- drop  output  1  sticky; set when an arrival is lost because its queue is full.
- served  output  SRV_W  total departures from all four queues, wrapping.
- conflict  output  1  present only with TL_SAFETY_CHK_EN.

Behaviour:
- Reset values: all queue counts 0, Ta/Tal/Tb/Tbl 0, drop 0, served 0, conflict 0, pace counters 0, previous-light registers 11 (RED).
- Sensor latency:
  - Sensors are a combinational decode of the registered counts (Ta = q_a != 0, and likewise for the others).
  - An arrival pulse in cycle n makes the sensor high from cycle n+1.
- Permission per street X:
  - GREEN permits the straight queue only.
  - LEFT permits the left queue only.
  - YELLOW and RED permit nothing.
- Pace counter pc_X per street, width ceil(log2 DEP_CYC):
  - If Lx differs from the registered previous Lx, or Lx is YELLOW/RED: pc_X <= 0.
  - Otherwise, if pc_X == DEP_CYC-1: pc_X <= 0 and a departure tick fires for the permitted queue.
  - Otherwise: pc_X <= pc_X+1.
- Resulting timing:
  - The first departure occurs DEP_CYC cycles after the light enters a permitting code.
  - Later departures occur every DEP_CYC cycles while the code holds.
- Queue update, evaluated per queue each cycle:
  - Arrival only: count+1; if the count is already at max, the count holds and drop <= 1.
  - Departure tick only: count-1 if nonzero. A tick on an empty queue is discarded with no underflow, and served is not incremented.
  - Arrival and effective departure in the same cycle: count unchanged, served increments. This holds even when the queue is full, with no drop.
- served increments once per effective departure. Streets A and B can both depart in one cycle (impossible in legal operation); served then adds 2. Wraps modulo 2^SRV_W.
- drop clears only on reset.
- Reset mid-operation takes priority over arrivals and departures in the same cycle.

Optional Feature:
- Macro: TL_SAFETY_CHK_EN.
- Defined:
  - Port conflict exists.
  - conflict is a sticky register set on the edge after any cycle in which La != 11 and Lb != 11 simultaneously.
  - conflict clears only on reset.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset with La=Lb=11 held; pulse arr_a 3 times -> q_a=3, Ta=1 from the cycle after the first pulse; no departures; served=0.
- q_a=3, then La=00 held, DEP_CYC=4 -> q_a reaches 2, 1, 0 at cycles 4, 8, 12 after La changes; Ta falls with the last; served=3.
- q_al=2, La switches 00->10 -> pace restarts; q_al decrements 4 and 8 cycles after the switch; q_a unaffected.
- Fill q_b to 15, then pulse arr_b with Lb=11 -> q_b stays 15, drop=1 and remains set until reset.
- q_bl=5, Lb=10, arr_bl asserted on a departure-tick cycle -> q_bl stays 5, served+1; reset asserted next cycle -> all outputs return to reset values.
- With TL_SAFETY_CHK_EN: La=00 and Lb=01 for one cycle -> conflict=1 and stays set; without the macro -> the bench compiles without the port.
